// File: rtl/reg_read_stage_pkg.sv
// Shared RV32I decode definitions for the operand-read stage and its
// immediate generator: opcode values, immediate formats and the NOP word.
package reg_read_stage_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Opcodes of the RV32I base set; anything else (including instr[1:0]!=11) is illegal.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Immediate format by opcode; FENCE/SYSTEM and unknown opcodes carry none.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_OP_IMM, OP_JALR: return IMM_I;
            OP_STORE:                    return IMM_S;
            OP_BRANCH:                   return IMM_B;
            OP_LUI, OP_AUIPC:            return IMM_U;
            OP_JAL:                      return IMM_J;
            default:                     return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_read_stage_if.sv
// Signal bundle of the operand-read stage: fetch side, register file side,
// writeback gating and the execute side. The stage uses the slave modport,
// its environment (fetch, register file, execute) the master modport.
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on the consumer's downstream ready
// (in_ready = !out_valid || out_ready), valid never depends on ready.
interface reg_read_stage_if;
    // fetch side
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    // register file read (1-cycle registered read)
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    // writeback request and gated register file write port
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    // execute side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc,
        input  rf_rd1, rf_rd2,
        input  wb_we, wb_rd, wb_data,
        input  out_ready,
        output in_ready,
        output rf_a1, rf_a2,
        output rf_we3, rf_a3, rf_wd3,
        output out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        output out_rd, out_opcode, out_funct3, out_funct7b5, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc,
        output rf_rd1, rf_rd2,
        output wb_we, wb_rd, wb_data,
        output out_ready,
        input  in_ready,
        input  rf_a1, rf_a2,
        input  rf_we3, rf_a3, rf_wd3,
        input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        input  out_rd, out_opcode, out_funct3, out_funct7b5, out_illegal
    );
endinterface

// File: rtl/reg_read_stage_imm_gen.sv
// RV32I immediate generator: classifies the instruction's immediate format
// and produces the sign-extended immediate. Purely combinational so it can
// also sit in front of the fetch branch predictor.
module reg_read_stage_imm_gen
    import reg_read_stage_pkg::*;
(
    input  logic [31:0] instr,
    output imm_fmt_e    fmt,
    output logic [31:0] imm
);

    assign fmt = imm_fmt_of(instr[6:0]);

    // Reassemble the scattered immediate bits; B and J offsets are halfword aligned.
    always_comb begin
        imm = 32'h0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/reg_read_stage.sv
// Decode/operand-read stage between fetch and execute. Holds one
// instruction, steers its rs1/rs2 addresses into the registered-read
// register file and presents decoded fields plus operands to execute.
// Also gates writeback so x0 is never written.
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst,
    reg_read_stage_if.slave    bus
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            ready;
    logic            accept;
    imm_fmt_e        fmt;
    logic [31:0]     imm;

    assign ready       = !valid_q || bus.out_ready;
    assign accept      = bus.in_valid && ready;
    assign bus.in_ready = ready;

    // Holding register: reset and flush empty it, accept loads it, consumption drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc_q    <= RESET_PC;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= bus.in_instr;
            pc_q    <= bus.in_pc;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // On accept the register file must sample the incoming instruction's
    // sources so the operands line up with it one cycle later; otherwise it
    // keeps re-reading the held sources so stall-time writebacks show up.
    assign bus.rf_a1 = accept ? bus.in_instr[19:15] : instr_q[19:15];
    assign bus.rf_a2 = accept ? bus.in_instr[24:20] : instr_q[24:20];

    // x0 is never written; independent of stall and flush.
    assign bus.rf_we3 = bus.wb_we && (bus.wb_rd != 5'd0);
    assign bus.rf_a3  = bus.wb_rd;
    assign bus.rf_wd3 = bus.wb_data;

    reg_read_stage_imm_gen u_imm_gen (
        .instr (instr_q),
        .fmt   (fmt),
        .imm   (imm)
    );

    // Decoded view of the held instruction. Unknown opcodes have no
    // immediate format, so out_imm is already zero for them.
    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = valid_q ? pc_q : RESET_PC;
    assign bus.out_opcode   = instr_q[6:0];
    assign bus.out_funct3   = instr_q[14:12];
    assign bus.out_funct7b5 = instr_q[30];
    assign bus.out_illegal  = !is_legal_opcode(instr_q[6:0]);
    assign bus.out_imm      = imm;
    // STORE and BRANCH (the S/B formats) reuse bits 11:7 as immediate, not a destination.
    assign bus.out_rd       = ((fmt == IMM_S) || (fmt == IMM_B)) ? 5'd0 : instr_q[11:7];
    assign bus.out_rs1_val  = (instr_q[19:15] == 5'd0) ? 32'h0 : bus.rf_rd1;
    assign bus.out_rs2_val  = (instr_q[24:20] == 5'd0) ? 32'h0 : bus.rf_rd2;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: behavioural register file, spec-level model of
// the held bundle and architectural registers compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_reg_read_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF0_0293; // addi x5,x0,-1
    localparam logic [31:0] I_ADD     = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB     = 32'h4020_8233; // sub  x4,x1,x2
    localparam logic [31:0] I_ADDI_5  = 32'h0050_0313; // addi x6,x0,5

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    reg_read_stage_if bus();

    reg_read_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file (write-first, registered read) ----------------
    logic [31:0] rf_mem [32];

    always @(posedge clk) begin
        if (bus.rf_we3) rf_mem[bus.rf_a3] <= bus.rf_wd3;
        bus.rf_rd1 <= (bus.rf_we3 && bus.rf_a3 == bus.rf_a1) ? bus.rf_wd3 : rf_mem[bus.rf_a1];
        bus.rf_rd2 <= (bus.rf_we3 && bus.rf_a3 == bus.rf_a2) ? bus.rf_wd3 : rf_mem[bus.rf_a2];
    end

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [31:0] s;
        s = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return (s << 12) | (i >> 20);
            7'h23: return (s << 12) | ((i >> 20) & 32'hFE0) | ((i >> 7) & 32'h1F);
            7'h63: return (s << 12) | ((i << 4) & 32'h800) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            7'h6F: return (s << 20) | (i & 32'h000F_F000) | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] m_rd(input logic [31:0] i);
        if (i[6:0] == 7'h23 || i[6:0] == 7'h63) return 5'd0;
        return i[11:7];
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : m_regs[r];
    endfunction

    // Model of the stage: one slot that is loaded when fetch offers and
    // execute has room, emptied on consumption, flush or reset.
    always @(posedge clk) begin
        if (bus.wb_we && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] <= bus.wb_data;
        if (rst) begin
            m_valid <= 1'b0;
            m_instr <= 32'h0000_0013;
            m_pc    <= RESET_PC;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_instr <= bus.in_instr;
            m_pc    <= bus.in_pc;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_acc;
            exp_acc = bus.in_valid && (!m_valid || bus.out_ready);
            check("m_out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
            check("m_in_ready", {31'b0, bus.in_ready}, {31'b0, !m_valid || bus.out_ready});
            check("m_rf_we3", {31'b0, bus.rf_we3}, {31'b0, bus.wb_we && bus.wb_rd != 5'd0});
            check("m_rf_a3", {27'b0, bus.rf_a3}, {27'b0, bus.wb_rd});
            check("m_rf_wd3", bus.rf_wd3, bus.wb_data);
            if (exp_acc) begin
                check("m_rf_a1", {27'b0, bus.rf_a1}, {27'b0, bus.in_instr[19:15]});
                check("m_rf_a2", {27'b0, bus.rf_a2}, {27'b0, bus.in_instr[24:20]});
            end else if (m_valid) begin
                check("m_rf_a1", {27'b0, bus.rf_a1}, {27'b0, m_instr[19:15]});
                check("m_rf_a2", {27'b0, bus.rf_a2}, {27'b0, m_instr[24:20]});
            end
            if (m_valid) begin
                check("m_out_pc", bus.out_pc, m_pc);
                check("m_rs1_val", bus.out_rs1_val, m_reg(m_instr[19:15]));
                check("m_rs2_val", bus.out_rs2_val, m_reg(m_instr[24:20]));
                check("m_imm", bus.out_imm, m_imm(m_instr));
                check("m_rd", {27'b0, bus.out_rd}, {27'b0, m_rd(m_instr)});
                check("m_opcode", {25'b0, bus.out_opcode}, {25'b0, m_instr[6:0]});
                check("m_funct3", {29'b0, bus.out_funct3}, {29'b0, m_instr[14:12]});
                check("m_funct7b5", {31'b0, bus.out_funct7b5}, {31'b0, m_instr[30]});
                check("m_illegal", {31'b0, bus.out_illegal}, {31'b0, m_illegal(m_instr)});
            end else begin
                check("m_idle_pc", bus.out_pc, RESET_PC);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_we   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        cyc();
        bus.wb_we   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    // immediate table: instruction, expected imm, expected rd, expected illegal
    logic [31:0] t_instr [7];
    logic [31:0] t_imm   [7];
    logic [4:0]  t_rd    [7];
    logic        t_ill   [7];

    initial begin
        t_instr[0] = 32'hFE20_AE23; t_imm[0] = 32'hFFFF_FFFC; t_rd[0] = 5'd0; t_ill[0] = 1'b0; // sw x2,-4(x1)
        t_instr[1] = 32'hFE20_8CE3; t_imm[1] = 32'hFFFF_FFF8; t_rd[1] = 5'd0; t_ill[1] = 1'b0; // beq x1,x2,-8
        t_instr[2] = 32'h1234_53B7; t_imm[2] = 32'h1234_5000; t_rd[2] = 5'd7; t_ill[2] = 1'b0; // lui x7,0x12345
        t_instr[3] = 32'h0010_00EF; t_imm[3] = 32'h0000_0800; t_rd[3] = 5'd1; t_ill[3] = 1'b0; // jal x1,+2048
        t_instr[4] = 32'hFF01_00E7; t_imm[4] = 32'hFFFF_FFF0; t_rd[4] = 5'd1; t_ill[4] = 1'b0; // jalr x1,-16(x2)
        t_instr[5] = 32'h0000_007F; t_imm[5] = 32'h0000_0000; t_rd[5] = 5'd0; t_ill[5] = 1'b1; // opcode 0x7F
        t_instr[6] = 32'h0000_0010; t_imm[6] = 32'h0000_0000; t_rd[6] = 5'd0; t_ill[6] = 1'b1; // instr[1:0]=00
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'h0;
            m_regs[i] = 32'h0;
        end
        rf_mem[0] = 32'hBAD0_0BAD;   // x0 masking must hide whatever the array holds
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.wb_we     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'h0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (2) cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'h0000_0100);
        check("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
        check("rst_out_imm", bus.out_imm, 32'h0);
        check("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        cyc();
        rst = 1'b0;

        // ADDI x5,x0,-1 at pc 0x40
        issue(I_ADDI_M1, 32'h40);
        @(negedge clk);
        check("addi_valid", {31'b0, bus.out_valid}, 32'd1);
        check("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
        check("addi_rd", {27'b0, bus.out_rd}, 32'd5);
        check("addi_rs1", bus.out_rs1_val, 32'h0);
        check("addi_pc", bus.out_pc, 32'h40);

        // preload, then ADD and SUB back to back
        cyc();
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        bus.in_valid = 1'b1;
        bus.in_instr = I_ADD;
        bus.in_pc    = 32'h44;
        cyc();
        bus.in_instr = I_SUB;
        bus.in_pc    = 32'h48;
        @(negedge clk);
        check("add_rs1", bus.out_rs1_val, 32'h11);
        check("add_rs2", bus.out_rs2_val, 32'h22);
        check("add_rd", {27'b0, bus.out_rd}, 32'd3);
        check("add_f7b5", {31'b0, bus.out_funct7b5}, 32'd0);
        check("add_in_ready", {31'b0, bus.in_ready}, 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sub_pc", bus.out_pc, 32'h48);
        check("sub_rd", {27'b0, bus.out_rd}, 32'd4);
        check("sub_f7b5", {31'b0, bus.out_funct7b5}, 32'd1);
        check("sub_rs2", bus.out_rs2_val, 32'h22);

        // stall three cycles with a writeback to x1 during the stall
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;
        bus.in_pc     = 32'h50;
        cyc();
        bus.in_instr  = I_SUB;
        bus.in_pc     = 32'h54;
        bus.wb_we     = 1'b1;
        bus.wb_rd     = 5'd1;
        bus.wb_data   = 32'h99;
        @(negedge clk);
        check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("stall_rs1_old", bus.out_rs1_val, 32'h11);
        cyc();
        bus.wb_we = 1'b0;
        @(negedge clk);
        check("stall_rs1_new", bus.out_rs1_val, 32'h99);
        check("stall_pc", bus.out_pc, 32'h50);
        cyc();
        @(negedge clk);
        check("stall_pc_hold", bus.out_pc, 32'h50);
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_stall_pc", bus.out_pc, 32'h54);
        check("post_stall_rs1", bus.out_rs1_val, 32'h99);

        // writeback to x0 is suppressed; x0 still reads as zero
        cyc();
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h0000_DEAD;
        @(negedge clk);
        check("x0_we3", {31'b0, bus.rf_we3}, 32'd0);
        cyc();
        bus.wb_we = 1'b0;
        issue(I_ADDI_5, 32'h58);
        @(negedge clk);
        check("x0_rs1", bus.out_rs1_val, 32'h0);
        check("x0_imm", bus.out_imm, 32'h5);
        check("x0_rd", {27'b0, bus.out_rd}, 32'd6);

        // flush together with an acceptable incoming instruction
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = I_ADD;
        bus.in_pc     = 32'h60;
        cyc();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_instr  = I_SUB;
        bus.in_pc     = 32'h64;
        @(negedge clk);
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_pc", bus.out_pc, 32'h0000_0100);
        cyc();
        @(negedge clk);
        check("flush_dropped", {31'b0, bus.out_valid}, 32'd0);

        // reset in the middle of a stall
        cyc();
        bus.out_ready = 1'b0;
        issue(I_ADD, 32'h70);
        @(negedge clk);
        check("rstall_valid_before", {31'b0, bus.out_valid}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rstall_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rstall_pc", bus.out_pc, 32'h0000_0100);
        check("rstall_rd", {27'b0, bus.out_rd}, 32'd0);
        check("rstall_imm", bus.out_imm, 32'h0);

        // immediate formats and illegal opcodes
        for (int k = 0; k < 7; k++) begin
            cyc();
            issue(t_instr[k], 32'h200 + 32'(k * 4));
            @(negedge clk);
            check("tbl_imm", bus.out_imm, t_imm[k]);
            check("tbl_rd", {27'b0, bus.out_rd}, {27'b0, t_rd[k]});
            check("tbl_illegal", {31'b0, bus.out_illegal}, {31'b0, t_ill[k]});
            check("tbl_valid", {31'b0, bus.out_valid}, 32'd1);
        end

        repeat (3) cyc();
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
